// File: rtl/neuron_mac_accel_pkg.sv
// Shared constants for the neuron MAC accelerator.
// Holds the default widths, the register word addresses, the CTRL/STATUS bit
// positions and the FSM state encoding.
package neuron_accel_pkg;

    localparam int DEF_DEPTH     = 64;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_FRAC_BITS = 8;
    localparam int DEF_ACC_W     = 40;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_PAIR   = 3'd2;
    localparam logic [2:0] ADDR_BIAS   = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;
    localparam logic [2:0] ADDR_COUNT  = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_RELU  = 2;
    localparam int CTRL_IRQ   = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_SAT  = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_FINAL = 2'd3;

endpackage

// File: rtl/neuron_mac_accel_if.sv
// Avalon-MM slave bus between the Nios CPU and the accelerator.
// master: drives address/write/writedata/read, receives readdata.
// slave : the accelerator side.
interface neuron_mac_accel_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (output address, output write, output writedata, output read,
                    input readdata);
    modport slave  (input address, input write, input writedata, input read,
                    output readdata);
endinterface

// File: rtl/neuron_pair_fifo.sv
// Show-ahead FIFO holding {weight, input} pairs.
// Ports: clk/reset (async, active-high), flush (sync empty), push/wr_data,
// pop (rd_data is the head entry, valid whenever !empty), full, empty, count.
// Push when full and pop when empty are ignored.
module neuron_pair_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/neuron_mac_accel.sv
// Neuron MAC accelerator: Avalon-MM slave that multiply-accumulates queued
// (weight, input) pairs, adds a bias, saturates, optionally applies ReLU.
// Ports: clk, reset (async, active-high), avs (Avalon slave, read latency 1),
// irq (level, done & irq_en).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; registers and FIFO accessible
// ST_RUN   | popping one pair per cycle into the 2-stage MAC pipeline
// ST_DRAIN | FIFO empty, two cycles to flush product and accumulate stages
// ST_FINAL | add bias, shift, saturate, ReLU, load RESULT, set done
module neuron_mac_accel
    import neuron_accel_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_W     = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    neuron_mac_accel_if.slave avs,
    output logic              irq
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] R_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] R_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                   state;
    logic                     drain_cnt;
    logic                     relu_en, irq_en, done, ovf, sat;
    logic signed [DATA_W-1:0] bias, result, r_sat;
    logic signed [PW-1:0]     prod;
    logic                     valid1, clip;
    logic signed [ACC_W-1:0]  acc, prod_ext, bias_ext, sum, r_shift;

    logic [PW-1:0]            fifo_rd;
    logic                     fifo_full, fifo_empty;
    logic [CW-1:0]            fifo_count;

    logic wr_ctrl, wr_status, wr_pair, wr_bias;
    logic clear_req, start_go, busy, push, pop;
    logic [31:0] rd_mux;

    assign busy      = (state != ST_IDLE);
    assign wr_ctrl   = avs.write && (avs.address == ADDR_CTRL);
    assign wr_status = avs.write && (avs.address == ADDR_STATUS);
    assign wr_pair   = avs.write && (avs.address == ADDR_PAIR);
    assign wr_bias   = avs.write && (avs.address == ADDR_BIAS);
    // clear has priority over a start carried in the same CTRL write
    assign clear_req = wr_ctrl & avs.writedata[CTRL_CLEAR];
    assign start_go  = wr_ctrl & avs.writedata[CTRL_START] & ~busy & ~clear_req;
    assign push      = wr_pair & ~fifo_full & ~busy;
    assign pop       = (state == ST_RUN) & ~fifo_empty;
    assign irq       = done & irq_en;

    neuron_pair_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (clear_req),
        .push    (push),
        .wr_data ({avs.writedata[16 +: DATA_W], avs.writedata[0 +: DATA_W]}),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Stage 1: product of the popped pair. Stage 2: accumulate, wrapping.
    assign prod_ext = ACC_W'(prod);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid1 <= 1'b0;
            prod   <= '0;
            acc    <= '0;
        end else begin
            valid1 <= pop & ~clear_req;
            if (pop)
                prod <= PW'($signed(fifo_rd[PW-1:DATA_W])) * PW'($signed(fifo_rd[DATA_W-1:0]));
            if (start_go)    acc <= '0;
            else if (valid1) acc <= acc + prod_ext;
        end
    end

    // Bias is aligned to the product's 2*FRAC_BITS scale before the add.
    assign bias_ext = ACC_W'(bias);
    assign sum      = acc + (bias_ext <<< FRAC_BITS);
    assign r_shift  = sum >>> FRAC_BITS;

    always_comb begin
        clip  = 1'b0;
        r_sat = r_shift[DATA_W-1:0];
        if (r_shift > R_MAX) begin
            r_sat = R_MAX[DATA_W-1:0];
            clip  = 1'b1;
        end else if (r_shift < R_MIN) begin
            r_sat = R_MIN[DATA_W-1:0];
            clip  = 1'b1;
        end
        if (relu_en && r_sat[DATA_W-1]) r_sat = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
            relu_en   <= 1'b0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            sat       <= 1'b0;
            bias      <= '0;
            result    <= '0;
        end else begin
            if (wr_ctrl) begin
                relu_en <= avs.writedata[CTRL_RELU];
                irq_en  <= avs.writedata[CTRL_IRQ];
            end
            if (wr_bias) bias <= avs.writedata[DATA_W-1:0];
            if (wr_status) begin
                if (avs.writedata[STAT_DONE]) done <= 1'b0;
                if (avs.writedata[STAT_OVF])  ovf  <= 1'b0;
                if (avs.writedata[STAT_SAT])  sat  <= 1'b0;
            end
            if (wr_pair & (fifo_full | busy)) ovf <= 1'b1;

            if (clear_req) begin
                state <= ST_IDLE;
                done  <= 1'b0;
                ovf   <= 1'b0;
                sat   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start_go) begin
                        state <= ST_RUN;
                        done  <= 1'b0;
                        sat   <= 1'b0;
                    end
                    ST_RUN: if (fifo_empty) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b1;
                    end
                    ST_DRAIN: begin
                        if (drain_cnt == 1'b0) state <= ST_FINAL;
                        else                   drain_cnt <= drain_cnt - 1'b1;
                    end
                    ST_FINAL: begin
                        state  <= ST_IDLE;
                        result <= r_sat;
                        done   <= 1'b1;
                        if (clip) sat <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            ADDR_CTRL: begin
                rd_mux[CTRL_RELU] = relu_en;
                rd_mux[CTRL_IRQ]  = irq_en;
            end
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done;
                rd_mux[STAT_OVF]  = ovf;
                rd_mux[STAT_SAT]  = sat;
            end
            ADDR_BIAS:   rd_mux = {{(32-DATA_W){1'b0}}, bias};
            ADDR_RESULT: rd_mux = 32'(result);
            ADDR_COUNT:  rd_mux = 32'(fifo_count);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         avs.readdata <= '0;
        else if (avs.read) avs.readdata <= rd_mux;
    end
endmodule
